// File: rtl/lenet_in_pkg.sv
// Shared geometry and writer state encoding for the LeNet input ping-pong buffer.
package lenet_in_pkg;
    localparam int unsigned W    = 32;
    localparam int unsigned H    = 32;
    localparam int unsigned AW   = 10;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned CW   = $clog2(W);
    localparam int unsigned RW   = $clog2(H);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FILL,
        WR_DROP
    } wr_state_t;
endpackage

// File: rtl/lenet_pingpong_ram.sv
// Simple dual-port RAM holding both frame banks; address is {bank, pixel index}.
module lenet_pingpong_ram #(
    parameter int unsigned ABITS = 11,
    parameter int unsigned DW    = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [DW-1:0]    rdata
);
    logic [DW-1:0] mem [1 << ABITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (srst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/lenet_input_buffer.sv
// Ping-pong frame capture between the pixel stream and the CNN reader.
// Optional frame-shape checking is enabled with `define LIB_FRAME_CHECK_EN.
module lenet_input_buffer
    import lenet_in_pkg::*;
(
    input  logic          clk,
    input  logic          srst,
    input  logic          in_valid,
    input  logic [7:0]    in_pixel,
    input  logic          in_line_last,
    input  logic          in_frame_last,
    input  logic [3:0]    in_tag,
    output logic          frame_ready,
    output logic [3:0]    frame_tag,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_done,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    output logic          frame_err
);
    wr_state_t   wr_state;
    logic [1:0]  full, full_nxt;
    logic [3:0]  tag_q [2];
    logic [3:0]  tag_nxt [2];
    logic [3:0]  cur_tag, tag_src;
    logic        wr_bank, rd_bank, rd_nxt;
    logic [AW:0] idx;
    logic        err_drop;
    logic        shape_bad, complete, drop_end, err_end, rel;
    logic        we;
    logic [AW:0] waddr;

    always_comb begin
        complete = 1'b0;
        drop_end = 1'b0;
        err_end  = 1'b0;
        case (wr_state)
            WR_IDLE: if (in_valid) begin
                if (full[wr_bank])  drop_end = in_frame_last;
                else if (shape_bad) err_end  = in_frame_last;
                else                complete = in_frame_last;
            end
            WR_FILL: if (in_valid && in_frame_last) begin
                if (shape_bad) err_end  = 1'b1;
                else           complete = 1'b1;
            end
            WR_DROP: if (in_valid && in_frame_last) begin
                if (err_drop) err_end  = 1'b1;
                else          drop_end = 1'b1;
            end
            default: ;
        endcase
    end

    assign rel     = frame_done & frame_ready;
    assign tag_src = (wr_state == WR_IDLE) ? in_tag : cur_tag;
    assign rd_nxt  = rd_bank ^ rel;

    // Completion and release always target different banks, so both may apply.
    always_comb begin
        full_nxt = full;
        tag_nxt  = tag_q;
        if (complete) begin
            full_nxt[wr_bank] = 1'b1;
            tag_nxt[wr_bank]  = tag_src;
        end
        if (rel) full_nxt[rd_bank] = 1'b0;
    end

    assign we    = in_valid && ((wr_state == WR_IDLE && !full[wr_bank]) ||
                                (wr_state == WR_FILL && idx < (AW+1)'(NPIX)));
    assign waddr = {wr_bank, (wr_state == WR_IDLE) ? {AW{1'b0}} : idx[AW-1:0]};

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_state    <= WR_IDLE;
            full        <= '0;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
            cur_tag     <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            idx         <= '0;
            err_drop    <= 1'b0;
            frame_ready <= 1'b0;
            frame_tag   <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            full        <= full_nxt;
            tag_q       <= tag_nxt;
            rd_bank     <= rd_nxt;
            // Forced low on a release so the reader always sees a gap between frames.
            frame_ready <= full_nxt[rd_nxt] & ~rel;
            frame_tag   <= tag_nxt[rd_nxt];
            overflow    <= drop_end;
            if (drop_end && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            if (complete) wr_bank <= ~wr_bank;

            case (wr_state)
                WR_IDLE: if (in_valid && !in_frame_last) begin
                    if (full[wr_bank]) begin
                        wr_state <= WR_DROP;
                        err_drop <= 1'b0;
                    end else if (shape_bad) begin
                        wr_state <= WR_DROP;
                        err_drop <= 1'b1;
                    end else begin
                        wr_state <= WR_FILL;
                        idx      <= (AW+1)'(1);
                        cur_tag  <= in_tag;
                    end
                end
                WR_FILL: if (in_valid) begin
                    if (in_frame_last) begin
                        wr_state <= WR_IDLE;
                    end else if (shape_bad) begin
                        wr_state <= WR_DROP;
                        err_drop <= 1'b1;
                    end else if (idx != (AW+1)'(NPIX)) begin
                        idx <= idx + 1'b1;
                    end
                end
                WR_DROP: if (in_valid && in_frame_last) wr_state <= WR_IDLE;
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

`ifdef LIB_FRAME_CHECK_EN
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          at_eol, at_eof;

    // In WR_IDLE the incoming pixel is column 0 of row 0 regardless of col/row.
    always_comb begin
        at_eol    = (wr_state == WR_FILL) && (col == CW'(W-1));
        at_eof    = at_eol && (row == RW'(H-1));
        shape_bad = (in_line_last != at_eol) || (in_frame_last != at_eof);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            col       <= '0;
            row       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_end;
            if (in_valid) begin
                if (wr_state == WR_IDLE) begin
                    col <= CW'(1);
                    row <= '0;
                end else if (wr_state == WR_FILL) begin
                    if (col == CW'(W-1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_cfg;
    assign shape_bad  = 1'b0;
    assign frame_err  = 1'b0;
    assign unused_cfg = in_line_last ^ err_end;
`endif

    lenet_pingpong_ram #(
        .ABITS (AW + 1),
        .DW    (8)
    ) u_ram (
        .clk   (clk),
        .srst  (srst),
        .we    (we),
        .waddr (waddr),
        .wdata (in_pixel),
        .re    (rd_en),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_lenet_input_buffer.sv
// Randomized self-checking bench for lenet_input_buffer with a frame-level bank model.
module tb_lenet_input_buffer;
    localparam int NPIX = 1024;

    logic       clk = 1'b0;
    logic       srst, in_valid, in_line_last, in_frame_last, rd_en, frame_done;
    logic [7:0] in_pixel;
    logic [3:0] in_tag;
    logic [9:0] rd_addr;
    logic       frame_ready, overflow, frame_err;
    logic [3:0] frame_tag;
    logic [7:0] rd_data, drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: two banks of stored frames plus pointers and drop counter.
    bit         m_full [2];
    logic [3:0] m_tag  [2];
    logic [7:0] m_mem  [2][NPIX];
    logic [7:0] fbuf   [NPIX];
    int         m_wr, m_rd, m_drop;

    always #5 clk = ~clk;

    lenet_input_buffer dut (
        .clk           (clk),
        .srst          (srst),
        .in_valid      (in_valid),
        .in_pixel      (in_pixel),
        .in_line_last  (in_line_last),
        .in_frame_last (in_frame_last),
        .in_tag        (in_tag),
        .frame_ready   (frame_ready),
        .frame_tag     (frame_tag),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .frame_err     (frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_line_last  = 1'b0;
        in_frame_last = 1'b0;
        frame_done    = 1'b0;
        rd_en         = 1'b0;
    endtask

    task automatic check_ready_state(input string name);
        check({name, "_ready"}, frame_ready, m_full[m_rd]);
        if (m_full[m_rd]) check({name, "_tag"}, frame_tag, m_tag[m_rd]);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        idle_inputs();
        tick();
        tick();
        srst    = 1'b0;
        m_full  = '{0, 0};
        m_wr    = 0;
        m_rd    = 0;
        m_drop  = 0;
        check("rst_ready", frame_ready, 0);
        check("rst_tag", frame_tag, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_frame_err", frame_err, 0);
    endtask

    task automatic send_frame(input int npix, input logic [3:0] t, input bit rnd,
                              input int bad_col, input bit done_last);
        bit accept, shape_ok, done_eff, exp_over, exp_err;
        int col, row;
        accept   = !m_full[m_wr];
        shape_ok = 1'b1;
`ifdef LIB_FRAME_CHECK_EN
        shape_ok = (npix == NPIX) && (bad_col < 0);
`endif
        for (int i = 0; i < npix; i++) begin
            while ($urandom_range(7) == 0) begin
                in_valid = 1'b0;
                in_pixel = 8'($urandom);
                tick();
            end
            if (i == npix - 1) check("pre_last_ready", frame_ready, m_full[m_rd]);
            col           = i % 32;
            row           = i / 32;
            fbuf[i]       = rnd ? 8'($urandom) : (8'(i) ^ 8'h80);
            in_valid      = 1'b1;
            in_pixel      = fbuf[i];
            in_tag        = (i == 0) ? t : 4'($urandom);
            in_line_last  = (col == 31) || (row == 0 && col == bad_col);
            in_frame_last = (i == npix - 1);
            frame_done    = done_last && (i == npix - 1);
            tick();
        end
        idle_inputs();
        done_eff = done_last && m_full[m_rd];
        exp_over = 1'b0;
        exp_err  = 1'b0;
        if (!accept) begin
            exp_over = 1'b1;
            if (m_drop < 255) m_drop++;
        end else if (!shape_ok) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < npix; i++) m_mem[m_wr][i] = fbuf[i];
            m_full[m_wr] = 1'b1;
            m_tag[m_wr]  = t;
            m_wr         = 1 - m_wr;
        end
        if (done_eff) begin
            m_full[m_rd] = 1'b0;
            m_rd         = 1 - m_rd;
        end
        check("end_overflow", overflow, exp_over);
        check("end_frame_err", frame_err, exp_err);
        check("end_drop_cnt", drop_cnt, m_drop);
        check("end_ready", frame_ready, done_eff ? 1'b0 : m_full[m_rd]);
        if (!done_eff && m_full[m_rd]) check("end_tag", frame_tag, m_tag[m_rd]);
        rd_en   = 1'b1;
        rd_addr = 10'(npix - 1);
        tick();
        rd_en = 1'b0;
        if (m_full[m_rd]) check("last_px_rd", rd_data, m_mem[m_rd][npix-1]);
        check("post_overflow", overflow, 0);
        check("post_frame_err", frame_err, 0);
        check_ready_state("post");
    endtask

    task automatic do_done();
        bit done_eff;
        done_eff   = m_full[m_rd];
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        if (done_eff) begin
            m_full[m_rd] = 1'b0;
            m_rd         = 1 - m_rd;
        end
        check("done_ready_low", frame_ready, 0);
        tick();
        check_ready_state("after_done");
    endtask

    task automatic read_at(input int a);
        bit         ok;
        logic [7:0] exp;
        rd_en   = 1'b1;
        rd_addr = 10'(a);
        tick();
        rd_en   = 1'b0;
        rd_addr = 10'($urandom);
        ok      = m_full[m_rd];
        exp     = m_mem[m_rd][a];
        if (ok) check("rd", rd_data, exp);
        tick();
        if (ok) check("rd_hold", rd_data, exp);
    endtask

    task automatic read_random(input int n);
        for (int k = 0; k < n; k++) read_at($urandom_range(NPIX - 1));
    endtask

    initial begin
        srst     = 1'b0;
        in_pixel = '0;
        in_tag   = '0;
        rd_addr  = '0;
        idle_inputs();
        do_reset();

        // Ramp frame, tag 5: last pixel reads back as 127.
        send_frame(NPIX, 4'd5, 1'b0, -1, 1'b0);
        read_at(NPIX - 1);
        check("px1023", rd_data, 8'd127);
        read_random(6);

        // Second frame fills bank 1; third is dropped.
        send_frame(NPIX, 4'd9, 1'b1, -1, 1'b0);
        send_frame(NPIX, 4'd3, 1'b1, -1, 1'b0);
        read_random(4);
        do_done();
        read_random(6);
        do_done();
        do_done();

        // Release coinciding with completion of the next bank.
        send_frame(NPIX, 4'd1, 1'b1, -1, 1'b0);
        send_frame(NPIX, 4'd2, 1'b1, -1, 1'b1);
        read_random(6);
        do_done();

        // Reset in the middle of a frame headed for bank 1.
        send_frame(NPIX, 4'd4, 1'b1, -1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            in_valid      = 1'b1;
            in_pixel      = 8'($urandom);
            in_tag        = 4'($urandom);
            in_line_last  = ((i % 32) == 31);
            in_frame_last = 1'b0;
            tick();
        end
        do_reset();
        send_frame(NPIX, 4'd7, 1'b1, -1, 1'b0);
        read_random(6);
        do_done();

        // Malformed line, then a good frame; single-pixel frame afterwards.
        send_frame(NPIX, 4'd6, 1'b1, 30, 1'b0);
        send_frame(NPIX, 4'd8, 1'b1, -1, 1'b0);
        read_random(6);
        do_done();
        send_frame(1, 4'd11, 1'b1, -1, 1'b0);
        read_at(0);
        do_done();

        // Fill both banks, then drop enough frames to saturate the counter.
        while (!(m_full[0] && m_full[1])) send_frame(NPIX, 4'($urandom), 1'b1, -1, 1'b0);
        for (int k = 0; k < 300; k++) send_frame($urandom_range(1, 3), 4'($urandom), 1'b1, -1, 1'b0);
        check("drop_sat", drop_cnt, 8'd255);
        read_random(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
